frame_buffer_pingpong: RTL



---
 rtl/frame_buffer_pingpong.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/frame_buffer_pingpong.sv
// frame_buffer_pingpong
// Double-buffered (ping-pong) pixel frame store sitting between the renderer
// and the VGA scan-out. The renderer writes the back bank by (x, y) while the
// scan-out reads the front bank with one cycle of latency. Bank swaps are
// deferred to a display frame boundary so a frame is never shown torn.
//
// Build option: define FB_CLEAR_EN to include the back-bank clear engine.
// Without it, clear_req/clear_value are ignored and clear_busy/wr_dropped
// are tied low.
//
// Strobe semantics: every control input (wr_en, rd_en, swap_req, clear_req,
// frame_start) is a single-cycle qualifier sampled on the rising clock edge;
// there is no back-pressure. The block answers with registered single-cycle
// pulses (rd_valid, swap_done, wr_dropped) in the cycle after the edge that
// sampled the request, and with levels (swap_pending, clear_busy) that track
// accepted-but-unfinished work.
module frame_buffer_pingpong #(
  parameter int DATA_WIDTH = 12,
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 10
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [X_WIDTH-1:0]    wr_x,
  input  logic [Y_WIDTH-1:0]    wr_y,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [X_WIDTH-1:0]    rd_x,
  input  logic [Y_WIDTH-1:0]    rd_y,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  frame_start,
  input  logic                  swap_req,
  output logic                  swap_pending,
  output logic                  swap_done,
  output logic                  front_sel,
  input  logic                  clear_req,
  input  logic [DATA_WIDTH-1:0] clear_value,
  output logic                  clear_busy,
  output logic                  wr_dropped,
  output logic                  clear_state
);

  // Bank address width is derived from the coordinate widths.
  localparam int ADDR_WIDTH = X_WIDTH + Y_WIDTH;
  localparam int DEPTH      = 2 << ADDR_WIDTH;

  // Both banks share one array, indexed {bank, y, x}; contents are not reset.
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic                  clearing;
  logic                  mem_we;
  logic [ADDR_WIDTH:0]   mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  swap_go;

`ifdef FB_CLEAR_EN
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clear_state_t;

  clear_state_t          state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] fill_value;

  // Clear FSM: walks cnt over the whole back bank, one pixel per cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      fill_value <= '0;
      clear_busy <= 1'b0;
      wr_dropped <= 1'b0;
    end else begin
      wr_dropped <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req) begin
            state      <= CLEAR;
            cnt        <= '0;
            fill_value <= clear_value;
            clear_busy <= 1'b1;
          end
        end
        CLEAR: begin
          cnt        <= cnt + ADDR_WIDTH'(1);
          // The fill owns the write port, so renderer writes are lost.
          wr_dropped <= wr_en;
          if (cnt == '1) begin
            state      <= IDLE;
            clear_busy <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          clear_busy <= 1'b0;
        end
      endcase
    end
  end

  assign clearing    = (state == CLEAR);
  assign clear_state = state;
`else
  // No clear engine: the back bank is only written by the renderer.
  assign clearing    = 1'b0;
  assign clear_busy  = 1'b0;
  assign wr_dropped  = 1'b0;
  assign clear_state = 1'b0;

  logic unused_clear;
  assign unused_clear = ^{clear_req, clear_value};
`endif

  // Write port mux: the fill engine takes priority over renderer writes.
  always_comb begin
    mem_we    = wr_en;
    mem_waddr = {~front_sel, wr_y, wr_x};
    mem_wdata = wr_data;
`ifdef FB_CLEAR_EN
    if (clearing) begin
      mem_we    = 1'b1;
      mem_waddr = {~front_sel, cnt};
      mem_wdata = fill_value;
    end
`endif
  end

  // Pixel store write; the back bank is always ~front_sel.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered front-bank read; rd_data holds when rd_en is low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= mem[{front_sel, rd_y, rd_x}];
      end
    end
  end

  // A swap fires at a frame boundary when one is pending or requested in the
  // same cycle, but never while the back bank is still being cleared.
  assign swap_go = frame_start && (swap_pending || swap_req) && !clear_busy;

  // Swap control: hold the request until the next usable frame boundary.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      swap_done <= swap_go;
      if (swap_go) begin
        front_sel    <= ~front_sel;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

endmodule
